// File: rtl/pll_rst_ctl_if.sv
// Signal bundle between the PLL reset controller and the PLL / system side.
// The controller uses the slave view; the PLL-side environment uses master.
interface pll_rst_ctl_if;
  logic       pll_lock;
  logic       soft_req;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       lock_ok;
  logic       fail;
  logic [2:0] retry_cnt;

  modport master (
    output pll_lock, soft_req,
    input  pll_rst, sys_rst_n, lock_ok, fail, retry_cnt
  );

  modport slave (
    input  pll_lock, soft_req,
    output pll_rst, sys_rst_n, lock_ok, fail, retry_cnt
  );
endinterface

// File: rtl/pll_rst_ctl.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases
// the system reset; retries a bounded number of times before latching fail.
module pll_rst_ctl #(
  parameter int unsigned PLL_RST_CYC = 24,
  parameter int unsigned LOCK_TMO    = 24000,
  parameter int unsigned STABLE_CYC  = 240,
  parameter int unsigned MAX_RETRY   = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  pll_rst_ctl_if.slave  bus
);

  localparam int unsigned MAX_A   = (PLL_RST_CYC > LOCK_TMO) ? PLL_RST_CYC : LOCK_TMO;
  localparam int unsigned CNT_MAX = (MAX_A > STABLE_CYC) ? MAX_A : STABLE_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PRST_LAST = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_PRST,
    S_WAIT,
    S_STAB,
    S_RUN,
    S_FAIL
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sync_q;
  logic             pll_rst_q;
  logic             sys_rst_n_q;
  logic             lock_ok_q;
  logic             fail_q;
  logic [2:0]       retry_q;

  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       retry_d;
  logic             lock_s;
  logic             attempt_fail;

  assign lock_s = sync_q[1];

  // One lock attempt is lost either by timing out in WAIT or by a dropout in STAB.
  always_comb begin
    cnt_d        = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    retry_d      = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
    attempt_fail = 1'b0;
    if (state_q == S_WAIT && !lock_s && cnt_q == TMO_LAST) begin
      attempt_fail = 1'b1;
    end
    if (state_q == S_STAB && !lock_s) begin
      attempt_fail = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PRST;
      cnt_q       <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.pll_lock};
      if (attempt_fail) begin
        retry_q   <= retry_d;
        cnt_q     <= '0;
        pll_rst_q <= 1'b1;
        if (retry_d == RETRY_LIM) begin
          state_q <= S_FAIL;
          fail_q  <= 1'b1;
        end else begin
          state_q <= S_PRST;
        end
      end else begin
        case (state_q)
          S_PRST: begin
            if (cnt_q == PRST_LAST) begin
              state_q   <= S_WAIT;
              cnt_q     <= '0;
              pll_rst_q <= 1'b0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_WAIT: begin
            if (lock_s) begin
              state_q <= S_STAB;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_STAB: begin
            if (cnt_q == STAB_LAST) begin
              state_q     <= S_RUN;
              cnt_q       <= '0;
              sys_rst_n_q <= 1'b1;
              lock_ok_q   <= 1'b1;
              retry_q     <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          S_RUN: begin
            // Lock loss and a soft request share one branch, so they yield one pulse.
            if (!lock_s || bus.soft_req) begin
              state_q     <= S_PRST;
              cnt_q       <= '0;
              pll_rst_q   <= 1'b1;
              sys_rst_n_q <= 1'b0;
              lock_ok_q   <= 1'b0;
            end
          end
          S_FAIL: begin
            if (bus.soft_req) begin
              state_q <= S_PRST;
              cnt_q   <= '0;
              fail_q  <= 1'b0;
              retry_q <= '0;
            end
          end
          default: begin
            state_q     <= S_PRST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            lock_ok_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.lock_ok   = lock_ok_q;
  assign bus.fail      = fail_q;
  assign bus.retry_cnt = retry_q;

endmodule
